// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the BCD conversion stage that
// follows the ALU.
package alu_pkg;

    // Binary operand width and number of packed BCD output digits.
    localparam int DATA_W     = 8;
    localparam int BCD_DIGITS = 3;

    // One double-dabble step per operand bit.
    localparam int STEP_COUNT = 8;

    // Width of the step counter; wide enough to hold STEP_COUNT.
    localparam int CNT_W      = 4;

    // Converter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : alu_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit packed BCD converter.
// A start seen in IDLE captures the operand and flags, eight shift-add-3
// steps follow, and one DONE cycle presents the new result with a pulse.
// Outputs hold the last completed conversion until the next one finishes.
module bin2bcd_seq #(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int BCD_DIGITS = alu_pkg::BCD_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       result,
    input  logic                    sign,
    input  logic                    overflow,
    output logic                    ready,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    bcd_sign,
    output logic                    bcd_ovf
);

    import alu_pkg::*;

    localparam int BCD_W = 4 * BCD_DIGITS;

    // Registered state.
    state_t             r_state;
    logic [DATA_W-1:0]  r_operand;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic               r_sign;
    logic               r_ovf;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_sign;
    logic               r_bcd_ovf;

    // Combinational next values.
    state_t                  w_state_next;
    logic [DATA_W-1:0]       w_operand_next;
    logic [BCD_W-1:0]        w_scratch_next;
    logic [CNT_W-1:0]        w_count_next;
    logic [BCD_W-1:0]        w_scratch_adj;
    logic [BCD_W+DATA_W-1:0] w_shifted;
    logic                    w_capture;
    logic                    w_load_out;

    // One add-3 corrector per scratch digit.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_scratch_adj[4*g +: 4])
        );
    end

    // Corrected scratch and operand shifted left together by one bit.
    assign w_shifted = {w_scratch_adj, r_operand} << 1;

    // Next-state, capture and double-dabble step logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        w_state_next   = r_state;
        w_operand_next = r_operand;
        w_scratch_next = r_scratch;
        w_count_next   = r_count;
        w_capture      = 1'b0;
        w_load_out     = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture      = 1'b1;
                    w_operand_next = result;
                    w_scratch_next = '0;
                    w_count_next   = '0;
                    w_state_next   = SHIFT;
                end
            end
            SHIFT: begin
                w_scratch_next = w_shifted[BCD_W+DATA_W-1:DATA_W];
                w_operand_next = w_shifted[DATA_W-1:0];
                w_count_next   = r_count + 1'b1;
                // The step taken on this edge is the last one.
                if (r_count == CNT_W'(STEP_COUNT - 1)) begin
                    w_load_out   = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // All registers; asynchronous active-low reset aborts any conversion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_operand  <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_sign     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_bcd_sign <= 1'b0;
            r_bcd_ovf  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples values from before this edge.
            r_state   <= w_state_next;
            r_operand <= w_operand_next;
            r_scratch <= w_scratch_next;
            r_count   <= w_count_next;
            if (w_capture) begin
                r_sign <= sign;
                r_ovf  <= overflow;
            end
            if (w_load_out) begin
                r_bcd      <= w_scratch_next;
                r_bcd_sign <= r_sign;
                r_bcd_ovf  <= r_ovf;
            end
        end
    end

    assign ready    = (r_state == IDLE);
    assign done     = (r_state == DONE);
    assign bcd      = r_bcd;
    assign bcd_sign = r_bcd_sign;
    assign bcd_ovf  = r_bcd_ovf;

endmodule : bin2bcd_seq
